uart_bus_master: RTL and testbench

Serial debug initiator. It receives 8N1 command frames on a UART line and executes them as single 32-bit transactions on the SoC native memory bus, acting as a bus master alongside the CPU through the bus arbiter. It returns a status or read-data reply on the UART TX line. It is the initiator counterpart to the memory-mapped UART responder: it loads and inspects memory over the same serial link without firmware.

---
 rtl/uart_bus_master.sv | 204 ++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// uart_bus_master: executes 8N1 UART command frames as single 32-bit bus transactions and replies on TX
module uart_bus_master #(
   parameter int CLK_DIV     = 104,
   parameter int BUS_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int TW = $clog2(BUS_TIMEOUT + 1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(BUS_TIMEOUT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {F_IDLE, F_ADDR, F_DATA, F_BUS, F_RESP} f_state_t;

   logic [2:0]    sync_q, sync_d;
   rx_state_t     rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic          rx_done;
   f_state_t      f_q, f_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic          wr_q, wr_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rsp_q, rsp_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic [TW-1:0] to_q, to_d;
   logic [1:0]    rsp_n_q, rsp_n_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic          tx_q, tx_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic [9:0]    frame;
   logic          rx_line, rx_fall;

   // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection
   assign sync_d  = {sync_q[1:0], uart_rx};
   assign rx_line = sync_q[1];
   assign rx_fall = sync_q[2] & ~sync_q[1];

   // RX bit timing: start-bit recheck at half period, then sample every CLK_DIV cycles
   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q + 1'b1;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      rx_done  = 1'b0;
      case (rx_st_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            rx_st_d  = rx_fall ? RX_START : RX_IDLE;
         end
         RX_START: if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx_line ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt_q == DIV_LAST) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_line, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 1'b1;
            rx_st_d  = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
         end
         RX_STOP: if (rx_cnt_q == DIV_LAST) begin
            rx_cnt_d = '0;
            rx_done  = rx_line;
            rx_st_d  = RX_IDLE;
         end
         default: rx_st_d = RX_IDLE;
      endcase
   end

   // frame parsing, bus handshake with timeout, and reply serialization
   always_comb begin
      f_d      = f_q;
      bcnt_d   = bcnt_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      to_d     = to_q;
      rsp_d    = rsp_q;
      rsp_n_d  = rsp_n_q;
      tx_cnt_d = tx_cnt_q;
      tx_bit_d = tx_bit_q;
      case (f_q)
         F_IDLE: if (rx_done && (rx_sh_q == 8'h57 || rx_sh_q == 8'h52)) begin
            f_d     = F_ADDR;
            wr_d    = rx_sh_q == 8'h57;
            wstrb_d = {4{rx_sh_q == 8'h57}};
            bcnt_d  = '0;
         end
         F_ADDR: if (rx_done) begin
            addr_d = {rx_sh_q, addr_q[31:8]};
            bcnt_d = bcnt_q + 1'b1;
            to_d   = '0;
            f_d    = (bcnt_q == 2'd3) ? (wr_q ? F_DATA : F_BUS) : F_ADDR;
         end
         F_DATA: if (rx_done) begin
            wdata_d = {rx_sh_q, wdata_q[31:8]};
            bcnt_d  = bcnt_q + 1'b1;
            to_d    = '0;
            f_d     = (bcnt_q == 2'd3) ? F_BUS : F_DATA;
         end
         F_BUS: begin
            to_d     = to_q + 1'b1;
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (mem_ready) begin
               f_d     = F_RESP;
               rsp_d   = wr_q ? 32'h4B : mem_rdata;
               rsp_n_d = wr_q ? 2'd0 : 2'd3;
            end else if (to_q == TO_LAST) begin
               f_d     = F_RESP;
               rsp_d   = 32'h45;
               rsp_n_d = 2'd0;
            end
         end
         F_RESP: begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            if (tx_cnt_q == DIV_LAST) begin
               tx_cnt_d = '0;
               tx_bit_d = (tx_bit_q == 4'd9) ? 4'd0 : tx_bit_q + 1'b1;
               if (tx_bit_q == 4'd9) begin
                  f_d     = (rsp_n_q == 2'd0) ? F_IDLE : F_RESP;
                  rsp_d   = rsp_q >> 8;
                  rsp_n_d = rsp_n_q - 1'b1;
               end
            end
         end
         default: f_d = F_IDLE;
      endcase
      frame   = {1'b1, rsp_d[7:0], 1'b0};
      tx_d    = (f_d == F_RESP) ? frame[tx_bit_d] : 1'b1;
      valid_d = f_d == F_BUS;
      busy_d  = f_d == F_BUS || f_d == F_RESP;
   end

   // state registers; reset abandons any transaction without waiting for mem_ready
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q   <= '1;
         rx_st_q  <= RX_IDLE;
         rx_cnt_q <= '0;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
         f_q      <= F_IDLE;
         bcnt_q   <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         to_q     <= '0;
         rsp_q    <= '0;
         rsp_n_q  <= '0;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_q     <= 1'b1;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         rx_st_q  <= rx_st_d;
         rx_cnt_q <= rx_cnt_d;
         rx_bit_q <= rx_bit_d;
         rx_sh_q  <= rx_sh_d;
         f_q      <= f_d;
         bcnt_q   <= bcnt_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         to_q     <= to_d;
         rsp_q    <= rsp_d;
         rsp_n_q  <= rsp_n_d;
         tx_cnt_q <= tx_cnt_d;
         tx_bit_q <= tx_bit_d;
         tx_q     <= tx_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign uart_tx   = tx_q;
   assign mem_valid = valid_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed frames with a bus responder, TX decoder and bus monitor
module tb_uart_bus_master;
   localparam int DIV = 8;

   logic        clk = 1'b0;
   logic        reset_n, uart_rx, uart_tx, mem_valid, mem_ready, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int checks = 0, passes = 0;
   int pulses = 0, vlen = 0, unstable = 0, tx_stop_err = 0, cyc = 0;
   logic        v_prev = 1'b0;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_wstrb;
   logic [7:0]  txq[$];
   int          txt[$];
   logic [7:0]  frame[$];
   logic [7:0]  tb_b;
   int          tb_st;
   int          base, p0;

   uart_bus_master #(.CLK_DIV(DIV), .BUS_TIMEOUT(16)) dut (
      .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // bus monitor: pulse count, length of the latest pulse, captured request, stability
   always @(negedge clk) begin
      if (mem_valid === 1'b1) begin
         if (!v_prev) begin
            pulses++;
            vlen = 0;
            cap_addr = mem_addr;
            cap_wdata = mem_wdata;
            cap_wstrb = mem_wstrb;
         end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb)
            unstable++;
         vlen++;
      end
      v_prev = mem_valid === 1'b1;
   end

   // TX decoder: records each byte and the cycle its start bit began
   always begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
         tb_st = cyc;
         repeat (DIV / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            tb_b[i] = uart_tx;
         end
         repeat (DIV) @(negedge clk);
         if (uart_tx !== 1'b1) tx_stop_err++;
         txq.push_back(tb_b);
         txt.push_back(tb_st);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rx = stop;
      repeat (DIV) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic send_frame();
      foreach (frame[i]) send_byte(frame[i], 1'b1);
   endtask

   // waits for mem_valid, then raises mem_ready for one cycle after lat cycles (lat < 0: never)
   task automatic respond(input int lat, input logic [31:0] data);
      int n = 0;
      while (mem_valid !== 1'b1 && n < 1500) begin
         @(negedge clk);
         n++;
      end
      check("valid_seen", mem_valid, 1);
      check("busy_with_valid", busy, 1);
      if (lat >= 0) begin
         repeat (lat) @(negedge clk);
         mem_rdata = data;
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         mem_rdata = '0;
      end
   endtask

   task automatic get_reply(input int b0, input int n, input logic [31:0] exp);
      int k = 0;
      while (txq.size() < b0 + n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("reply_count", 32'(txq.size() - b0), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (b0 + i < txq.size()) begin
            check("reply_byte", {24'h0, txq[b0 + i]}, {24'h0, exp[8*i +: 8]});
            if (i > 0) check("reply_gap", 32'(txt[b0 + i] - txt[b0 + i - 1]), 32'(10 * DIV));
         end
      end
      check("busy_in_stop", busy, 1);
      repeat (DIV) @(negedge clk);
      check("busy_after", busy, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      uart_rx = 1'b1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", uart_tx, 1);
      check("rst_valid", mem_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_wstrb", mem_wstrb, 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      base = txq.size();
      frame = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      fork
         send_frame();
         respond(3, 32'h0);
      join
      check("wr_pulses", pulses, 1);
      check("wr_addr", cap_addr, 32'h00001000);
      check("wr_wdata", cap_wdata, 32'hDEADBEEF);
      check("wr_wstrb", cap_wstrb, 4'hF);
      check("wr_vlen", vlen, 4);
      get_reply(base, 1, 32'h4B);

      base = txq.size();
      frame = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
      fork
         send_frame();
         respond(0, 32'h12345678);
      join
      check("rd_valid_low_after_ready", mem_valid, 0);
      check("rd_vlen", vlen, 1);
      check("rd_addr", cap_addr, 32'h4);
      check("rd_wstrb", cap_wstrb, 4'h0);
      get_reply(base, 4, 32'h12345678);

      base = txq.size();
      frame = '{8'h52, 8'h00, 8'h20, 8'h00, 8'h00};
      fork
         send_frame();
         respond(-1, 32'h0);
      join
      get_reply(base, 1, 32'h45);
      check("to_vlen", vlen, 16);
      check("to_addr", cap_addr, 32'h2000);

      base = txq.size();
      frame = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
      fork
         send_frame();
         respond(1, 32'hCAFEF00D);
      join
      check("after_to_addr", cap_addr, 32'h8);
      get_reply(base, 4, 32'hCAFEF00D);

      p0 = pulses;
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      send_byte(8'h57, 1'b0);
      repeat (20) @(negedge clk);
      send_byte(8'h00, 1'b1);
      repeat (20) @(negedge clk);
      check("noise_no_pulse", pulses, p0);
      check("noise_busy", busy, 0);
      base = txq.size();
      frame = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
      fork
         send_frame();
         respond(0, 32'h0BADF00D);
      join
      check("noise_pulses", pulses, p0 + 1);
      check("noise_addr", cap_addr, 32'h10);
      check("noise_wstrb", cap_wstrb, 4'h0);
      get_reply(base, 4, 32'h0BADF00D);

      p0 = pulses;
      base = txq.size();
      frame = '{8'h52, 8'h14, 8'h00, 8'h00, 8'h00, 8'h57};
      fork
         send_frame();
         respond(0, 32'hA5A55A5A);
      join
      get_reply(base, 4, 32'hA5A55A5A);
      base = txq.size();
      frame = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
      fork
         send_frame();
         respond(0, 32'h0);
      join
      check("discard_pulses", pulses, p0 + 2);
      check("discard_addr", cap_addr, 32'h20);
      check("discard_wdata", cap_wdata, 32'h11223344);
      check("discard_wstrb", cap_wstrb, 4'hF);
      get_reply(base, 1, 32'h4B);

      base = txq.size();
      frame = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      fork
         send_frame();
         respond(-1, 32'h0);
      join
      repeat (3) @(negedge clk);
      check("pre_reset_valid", mem_valid, 1);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", mem_valid, 0);
      check("mid_rst_tx", uart_tx, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_addr", mem_addr, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      check("post_rst_no_reply", 32'(txq.size() - base), 0);
      check("post_rst_valid", mem_valid, 0);
      check("post_rst_busy", busy, 0);

      check("bus_stable", unstable, 0);
      check("tx_stop_bits", tx_stop_err, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
